// File: rtl/scratchpad_mem_responder_if.sv
// Request/response bundle of the kernel streaming access protocol.
// The master issues single-word requests; the slave acknowledges them.
interface scratchpad_mem_responder_if #(
   parameter int DATA_WID = 32
);
   logic                read_enable;
   logic [63:0]         read_addr;
   logic [63:0]         read_size;
   logic                write_enable;
   logic [63:0]         write_addr;
   logic [63:0]         write_size;
   logic [DATA_WID-1:0] write_data;
   logic [63:0]         read_ready;
   logic [63:0]         write_ready;
   logic [DATA_WID-1:0] read_data;

   modport master (
      output read_enable, read_addr, read_size,
      output write_enable, write_addr, write_size, write_data,
      input  read_ready, write_ready, read_data
   );

   modport slave (
      input  read_enable, read_addr, read_size,
      input  write_enable, write_addr, write_size, write_data,
      output read_ready, write_ready, read_data
   );
endinterface

// File: rtl/scratchpad_mem_responder.sv
// Scratchpad-backed memory responder: services one single-word read or write
// at a time and acknowledges it with a one-cycle ready pulse after a fixed latency.
module scratchpad_mem_responder #(
   parameter int          ADDR_WID  = 14,
   parameter int          DATA_WID  = 32,
   parameter logic [63:0] MEM_BASE  = 64'h0,
   parameter int          READ_LAT  = 4,
   parameter int          WRITE_LAT = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   scratchpad_mem_responder_if.slave bus,
   input  logic                      done,
   output logic                      busy,
   output logic                      err,
   output logic [31:0]               read_count,
   output logic [31:0]               write_count
);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

   localparam int                  CNT_WID   = 16;
   localparam logic [CNT_WID-1:0]  RD_LOAD   = CNT_WID'(READ_LAT - 1);
   localparam logic [CNT_WID-1:0]  WR_LOAD   = CNT_WID'(WRITE_LAT - 1);
   localparam logic [1:0]          ALIGN_OFF = ~MEM_BASE[1:0] + 2'd1;
   localparam logic [DATA_WID-1:0] ERR_DATA  = DATA_WID'(32'hDEADBEEF);

   state_t              state;
   logic [CNT_WID-1:0]  lat_cnt;
   logic [63:0]         req_addr;
   logic [63:0]         req_size;
   logic [DATA_WID-1:0] req_data;
   logic                done_seen;
   logic [DATA_WID-1:0] mem [2**ADDR_WID];

   logic                in_idle, accept_wr, accept_rd, collide, stray;
   logic                enter_rd, enter_wr;
   logic [63:0]         cur_addr, cur_size;
   logic [DATA_WID-1:0] cur_data;
   logic [64:0]         offset;
   logic [ADDR_WID-1:0] idx;
   logic                addr_ok, size_ok;

   assign in_idle   = (state == IDLE);
   assign accept_wr = in_idle && bus.write_enable;
   assign accept_rd = in_idle && bus.read_enable && !bus.write_enable;
   assign collide   = in_idle && bus.read_enable && bus.write_enable;
   assign stray     = !in_idle && (bus.read_enable || bus.write_enable);
   assign enter_rd  = (accept_rd && READ_LAT == 1) || (state == RD_WAIT && lat_cnt == CNT_WID'(1));
   assign enter_wr  = (accept_wr && WRITE_LAT == 1) || (state == WR_WAIT && lat_cnt == CNT_WID'(1));
   assign busy      = !in_idle;

   // Decode the live request in IDLE so a latency of 1 can respond at the accepting edge.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      cur_addr = req_addr;
      cur_size = req_size;
      cur_data = req_data;
      if (in_idle) begin
         cur_addr = bus.write_enable ? bus.write_addr : bus.read_addr;
         cur_size = bus.write_enable ? bus.write_size : bus.read_size;
         cur_data = bus.write_data;
      end
   end

   // offset[64] is the borrow (address below MEM_BASE); the low bits match
   // ALIGN_OFF exactly when the byte address itself is word aligned.
   assign offset  = {1'b0, cur_addr} - {1'b0, MEM_BASE};
   assign idx     = offset[ADDR_WID+1:2];
   assign addr_ok = !offset[64] && (offset[1:0] == ALIGN_OFF) && (offset[63:ADDR_WID+2] == '0);
   assign size_ok = (cur_size == 64'd4);

   // NOTE: the scratchpad is deliberately not reset; clearing every word would prevent RAM inference.
   always_ff @(posedge clk) begin
      if (enter_wr && addr_ok) mem[idx] <= cur_data;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         lat_cnt         <= '0;
         req_addr        <= '0;
         req_size        <= '0;
         req_data        <= '0;
         done_seen       <= 1'b0;
         err             <= 1'b0;
         read_count      <= '0;
         write_count     <= '0;
         bus.read_ready  <= '0;
         bus.write_ready <= '0;
         bus.read_data   <= '0;
      end else begin
         bus.read_ready  <= '0;
         bus.write_ready <= '0;
         if (done) done_seen <= 1'b1;
         if (collide || stray || ((enter_rd || enter_wr) && !(addr_ok && size_ok))) err <= 1'b1;
         if (enter_rd) begin
            bus.read_ready <= 64'd1;
            bus.read_data  <= addr_ok ? mem[idx] : ERR_DATA;
         end
         if (enter_wr) bus.write_ready <= 64'd1;

         case (state)
            IDLE: begin
               if (accept_wr) begin
                  req_addr <= bus.write_addr;
                  req_size <= bus.write_size;
                  req_data <= bus.write_data;
                  lat_cnt  <= WR_LOAD;
                  state    <= enter_wr ? WR_RESP : WR_WAIT;
               end else if (accept_rd) begin
                  req_addr <= bus.read_addr;
                  req_size <= bus.read_size;
                  lat_cnt  <= RD_LOAD;
                  state    <= enter_rd ? RD_RESP : RD_WAIT;
               end
            end
            RD_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (enter_rd) state <= RD_RESP;
            end
            WR_WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (enter_wr) state <= WR_RESP;
            end
            RD_RESP: begin
               state <= IDLE;
               if (!done_seen) read_count <= read_count + 32'd1;
            end
            WR_RESP: begin
               state <= IDLE;
               if (!done_seen) write_count <= write_count + 32'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/scratchpad_mem_responder.md
# scratchpad_mem_responder

Memory-side responder for the kernel streaming access protocol. It services single-word read and write requests from an accelerator wrapper using an internal word-addressed scratchpad. Each request is acknowledged with a one-cycle `read_ready`/`write_ready` pulse after a programmable latency. The block replaces the host memory model in standalone FPGA and simulation builds, so a kernel wrapper can run without an external DMA engine.

## Interface
- `ADDR_WID`, 14, scratchpad word-index width; depth is 2^ADDR_WID words.
- `DATA_WID`, 32, data word width.
- `MEM_BASE`, 64'h0, byte address that maps to word index 0.
- `READ_LAT`, 4, cycles from the request-accepting edge to the `read_ready` pulse; must be ≥1.
- `WRITE_LAT`, 2, cycles from the request-accepting edge to the `write_ready` pulse; must be ≥1.
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `read_enable`  in  1  one-cycle read request strobe.
- `read_addr`  in  64  byte address of the read.
- `read_size`  in  64  transfer size in bytes; only 4 is legal.
- `write_enable`  in  1  one-cycle write request strobe.
- `write_addr`  in  64  byte address of the write.
- `write_size`  in  64  transfer size in bytes; only 4 is legal.
- `write_data`  in  32  write payload; sampled together with `write_enable`.
- `done`  in  1  kernel completion; freezes the counters.
- `read_ready`  out  64  value 1 for exactly one cycle when `read_data` is valid, otherwise 0.
- `write_ready`  out  64  value 1 for exactly one cycle when the write has committed, otherwise 0.
- `read_data`  out  32  last read result; held until the next read response.
- `busy`  out  1  high whenever state ≠ IDLE.
- `err`  out  1  sticky protocol or address error flag.
- `read_count`  out  32  number of reads serviced.
- `write_count`  out  32  number of writes serviced.

## Operation
- State machine: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP.
- IDLE with `read_enable`=1: latch the address and size, load the latency counter with READ_LAT-1, then go to RD_WAIT. If READ_LAT=1, go directly to RD_RESP.
- IDLE with `write_enable`=1: latch the address, size and data, load the counter with WRITE_LAT-1, then go to WR_WAIT. If WRITE_LAT=1, go directly to WR_RESP.
- Both strobes high in IDLE: the write is accepted, the read is dropped, and `err` is set.
- RD_WAIT/WR_WAIT: decrement the counter each cycle. When it reaches 0, go to RD_RESP/WR_RESP.
- Address decode:
  - `idx = (addr - MEM_BASE) >> 2`.
  - The address is illegal if `addr < MEM_BASE`, if `addr[1:0]≠0`, or if `idx ≥ 2^ADDR_WID`.
- RD_RESP lasts one cycle:
  - `read_ready`=1.
  - `read_data` = mem[idx], or 32'hDEADBEEF if the address is illegal.
  - The next state is IDLE.
- WR_RESP lasts one cycle:
  - `write_ready`=1.
  - mem[idx] ← data if the address is legal; otherwise memory is untouched.
  - The next state is IDLE.
- An illegal address or a size ≠ 4 sets `err`, but the request is still acknowledged so the initiator never hangs.
- A strobe arriving in any state other than IDLE is ignored and sets `err`.
- `read_count`/`write_count` increment in RD_RESP/WR_RESP and wrap modulo 2^32. While `done` has been seen since reset, they hold.

## Timing
- Reset values:
  - state IDLE.
  - `read_ready`=0, `write_ready`=0, `read_data`=0, `busy`=0, `err`=0.
  - Both counters 0; the done-latch is cleared.
- Scratchpad contents are not reset.
- Request accepted at edge E0 → ready is high during the cycle after edge E0+LAT−1. With READ_LAT=4, that is the 4th cycle after the strobe cycle.
- Ready outputs are registered and never high for two consecutive cycles.
- IDLE is re-entered at the edge that drops ready. A strobe in the very next cycle, which is the initiator's earliest reissue, is accepted with no error.
- Sustained throughput is one access per LAT+1 cycles.
- Reset asserted mid-operation: outputs clear immediately without waiting for a clock edge. The in-flight request is dropped with no ready pulse and no memory write.
- A write to an index and a read of the same index issued next are ordered: the read returns the new data.

## Test plan
- Write 32'h12345678 to MEM_BASE+0x10 (WRITE_LAT=2) → `write_ready`=1 for exactly one cycle, 2 cycles after the strobe. Then read MEM_BASE+0x10 → `read_ready` pulses at cycle 4 with `read_data`=32'h12345678; counts are 1/1 and `err`=0.
- Back-to-back: 16 reads, each issued in the cycle right after the previous ready → all accepted, each spaced READ_LAT+1 cycles, `err`=0, `read_count`=16.
- Out-of-range cases → response delivered with the error data, memory unchanged, `err`=1:
  - Read at MEM_BASE+0x10000 → `read_data`=32'hDEADBEEF.
  - Write at MEM_BASE+0x2 → no memory change.
- Simultaneous `read_enable`/`write_enable` in IDLE → only `write_ready` pulses, `err`=1. A strobe during RD_WAIT is ignored.
- Assert `reset` in RD_WAIT → `busy`=0 and `read_ready` stays 0. Memory written before the reset reads back intact afterwards.
- Pulse `done`, then issue 2 more reads → responses still arrive and the counts stay frozen at their pre-`done` values.
